if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 77 +++++++
 tb/tb_if_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with PC register and IF/ID pipeline latch
// Priority per edge: rst > redirect (branch over jump) > stall > memory wait > fetch.
module if_stage (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] instr12,
  output logic [31:0] addp4out12,
  output logic [31:0] pc12,
  output logic        valid12,
  output logic [15:0] fetch_count
);

  logic [31:0] r_pc;
  logic [31:0] r_instr12;
  logic [31:0] r_addp4out12;
  logic [31:0] r_pc12;
  logic        r_valid12;
  logic [15:0] r_fetch_count;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  assign w_redirect = pcsrc | jump;
  // The branch resolved in EX is older than the jump in ID, so it wins.
  assign w_target   = pcsrc ? branch_target : jump_target;
  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= 32'h0;
      r_instr12     <= 32'h0;
      r_pc12        <= 32'h0;
      r_addp4out12  <= 32'h0;
      r_valid12     <= 1'b0;
      r_fetch_count <= 16'h0;
    end else if (w_redirect) begin
      r_pc         <= {w_target[31:2], 2'b00};
      r_instr12    <= 32'h0;
      r_pc12       <= 32'h0;
      r_addp4out12 <= 32'h0;
      r_valid12    <= 1'b0;
    end else if (stall) begin
      r_pc <= r_pc;
    end else if (!imem_ready) begin
      r_instr12    <= 32'h0;
      r_pc12       <= 32'h0;
      r_addp4out12 <= 32'h0;
      r_valid12    <= 1'b0;
    end else begin
      r_pc         <= w_pc_plus4;
      r_instr12    <= imem_rdata;
      r_pc12       <= r_pc;
      r_addp4out12 <= w_pc_plus4;
      r_valid12    <= 1'b1;
      if (r_fetch_count != 16'hFFFF) begin
        r_fetch_count <= r_fetch_count + 16'd1;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign instr12     = r_instr12;
  assign addp4out12  = r_addp4out12;
  assign pc12        = r_pc12;
  assign valid12     = r_valid12;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage
// Each step pushes the model's expected state; the post-edge sample pops and compares it.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] instr12;
  logic [31:0] addp4out12;
  logic [31:0] pc12;
  logic        valid12;
  logic [15:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc12;
    logic [31:0] addp4;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_pc, m_instr, m_pc12, m_addp4;
  logic        m_valid;
  logic [15:0] m_cnt;

  if_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .stall(stall), .pcsrc(pcsrc),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .instr12(instr12), .addp4out12(addp4out12), .pc12(pc12),
    .valid12(valid12), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic rdy, input logic [31:0] rd,
                       input logic st, input logic pb, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt);
    logic [31:0] t;
    if (r) begin
      m_pc = 0; m_instr = 0; m_pc12 = 0; m_addp4 = 0; m_valid = 0; m_cnt = 0;
    end else if (pb || jp) begin
      t = pb ? bt : jt;
      m_pc = t & 32'hFFFF_FFFC;
      m_instr = 0; m_pc12 = 0; m_addp4 = 0; m_valid = 0;
    end else if (st) begin
      // hold everything
    end else if (!rdy) begin
      m_instr = 0; m_pc12 = 0; m_addp4 = 0; m_valid = 0;
    end else begin
      m_instr = rd; m_pc12 = m_pc; m_addp4 = m_pc + 32'd4; m_pc = m_addp4; m_valid = 1;
      if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic [31:0] rd,
                      input logic st, input logic pb, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt);
    exp_t e;
    rst = r; imem_ready = rdy; imem_rdata = rd; stall = st;
    pcsrc = pb; branch_target = bt; jump = jp; jump_target = jt;
    model(r, rdy, rd, st, pb, bt, jp, jt);
    sb.push_back('{m_pc, m_instr, m_pc12, m_addp4, m_valid, m_cnt});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("imem_addr", imem_addr, e.addr);
      chk("instr12", instr12, e.instr);
      chk("pc12", pc12, e.pc12);
      chk("addp4out12", addp4out12, e.addp4);
      chk("valid12", {31'd0, valid12}, {31'd0, e.valid});
      chk("fetch_count", {16'd0, fetch_count}, {16'd0, e.cnt});
    end
  endtask

  task automatic fetch(input logic [31:0] rd);
    step(0, 1, rd, 0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    m_pc = 0; m_instr = 0; m_pc12 = 0; m_addp4 = 0; m_valid = 0; m_cnt = 0;

    // Reset state
    step(1, 1, 32'hAAAA_5555, 0, 0, 32'h0, 0, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, valid12}, 32'd0);

    // Sequential fetch with a two-cycle stall at pc=8
    fetch(32'h11);
    chk("seq_instr0", instr12, 32'h11);
    fetch(32'h22);
    chk("seq_pc12_1", pc12, 32'h4);
    chk("seq_addr_8", imem_addr, 32'h8);
    step(0, 1, 32'hBAD0, 1, 0, 32'h0, 0, 32'h0);
    step(0, 0, 32'hBAD1, 1, 0, 32'h0, 0, 32'h0);
    chk("stall_addr", imem_addr, 32'h8);
    chk("stall_instr", instr12, 32'h22);
    chk("stall_pc12", pc12, 32'h4);
    fetch(32'h33);
    chk("seq_instr2", instr12, 32'h33);
    chk("seq_pc12_2", pc12, 32'h8);
    chk("seq_addp4_2", addp4out12, 32'hC);
    chk("seq_count", {16'd0, fetch_count}, 32'd3);

    // Branch beats jump and stall
    step(0, 1, 32'hDEAD, 1, 1, 32'h100, 1, 32'h200);
    chk("redir_pc", imem_addr, 32'h100);
    chk("redir_instr", instr12, 32'h0);
    chk("redir_valid", {31'd0, valid12}, 32'd0);
    fetch(32'h44);

    // Redirect overrides memory wait; misaligned jump target then a bubble
    step(0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h203);
    chk("jmp_align", imem_addr, 32'h200);
    step(0, 0, 32'h55, 0, 0, 32'h0, 0, 32'h0);
    chk("bubble_pc", imem_addr, 32'h200);
    chk("bubble_valid", {31'd0, valid12}, 32'd0);
    fetch(32'h66);
    chk("after_bubble_pc12", pc12, 32'h200);

    // PC wrap
    step(0, 1, 32'h0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
    fetch(32'h77);
    chk("wrap_addp4", addp4out12, 32'h0);
    chk("wrap_pc", imem_addr, 32'h0);
    chk("wrap_pc12", pc12, 32'hFFFF_FFFC);

    // fetch_count saturation
    while (m_cnt != 16'hFFFF) fetch(32'h0000_0013);
    chk("sat_reach", {16'd0, fetch_count}, 32'h0000_FFFF);
    fetch(32'h88);
    chk("sat_hold", {16'd0, fetch_count}, 32'h0000_FFFF);

    // Reset during a stall with a valid instruction in IF/ID
    fetch(32'h99);
    step(1, 1, 32'h0, 1, 0, 32'h0, 0, 32'h0);
    chk("midrst_valid", {31'd0, valid12}, 32'd0);
    chk("midrst_count", {16'd0, fetch_count}, 32'd0);
    chk("midrst_addr", imem_addr, 32'h0);
    fetch(32'hAB);
    chk("post_rst_pc12", pc12, 32'h0);
    chk("post_rst_instr", instr12, 32'hAB);

    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
